// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Which requester received the most recent grant; drives round-robin priority.
  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } gnt_sel_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_CNT_WIDTH      = 32;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Enable-driven free-running counter that wraps modulo 2^Width; cleared by synchronous reset.
module mem_arb_perf_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between fetch and load/store.
// Handshake: a requester holds req/addr/data high until its ready_o pulses for one cycle; that
// pulse is mem_ready_i passed through while the requester owns the port, with rdata valid then.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DWidth        = 32,
  parameter int unsigned TimeoutCycles = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CntWidth      = DEF_CNT_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                imem_req_i,
  input  logic [DWidth-1:0]   imem_addr_i,
  output logic                imem_ready_o,
  output logic [DWidth-1:0]   imem_rdata_o,
  input  logic                dmem_req_i,
  input  logic                dmem_write_i,
  input  logic [DWidth-1:0]   dmem_addr_i,
  input  logic [DWidth-1:0]   dmem_wdata_i,
  output logic                dmem_ready_o,
  output logic [DWidth-1:0]   dmem_rdata_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [DWidth-1:0]   mem_addr_o,
  output logic [DWidth-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DWidth-1:0]   mem_rdata_i,
  output logic                err_o,
  output logic [CntWidth-1:0] perf_igrant_o,
  output logic [CntWidth-1:0] perf_dgrant_o,
  output logic [CntWidth-1:0] perf_stall_o,
  output logic [1:0]          dbg_state_o
);

  localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  gnt_sel_e            r_last;
  logic [DWidth-1:0]   r_addr;
  logic [DWidth-1:0]   r_wdata;
  logic                r_write;
  logic [TmoWidth-1:0] r_tmo_cnt;
  logic                r_err;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_busy;
  logic                w_waiting;
  logic                w_stall;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data wins a conflict unless it was the last one served.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_d = dmem_req_i && (!imem_req_i || (r_last == GNT_IMEM));
        w_grant_i = imem_req_i && !w_grant_d;
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I: begin
        imem_ready_o = mem_ready_i;
        if (mem_ready_i) w_state_nxt = ST_IDLE;
      end
      ST_BUSY_D: begin
        dmem_ready_o = mem_ready_i;
        if (mem_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_last  <= GNT_IMEM;
    end else if (w_grant_d) begin
      r_addr  <= dmem_addr_i;
      r_wdata <= dmem_wdata_i;
      r_write <= dmem_write_i;
      r_last  <= GNT_DMEM;
    end else if (w_grant_i) begin
      r_addr  <= imem_addr_i;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_last  <= GNT_IMEM;
    end
  end

  assign w_busy    = (r_state != ST_IDLE);
  assign w_waiting = w_busy && !mem_ready_i;

  // The count saturates at the limit; err stays set until reset and the transfer is not aborted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant_i || w_grant_d) begin
        r_tmo_cnt <= '0;
      end else if (w_waiting && (r_tmo_cnt != TmoWidth'(TimeoutCycles))) begin
        r_tmo_cnt <= r_tmo_cnt + TmoWidth'(1);
      end
      if (w_waiting && (r_tmo_cnt == TmoWidth'(TimeoutCycles - 1))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_stall = (imem_req_i && !imem_ready_o) || (dmem_req_i && !dmem_ready_o);

  mem_arb_perf_cnt #(.Width(CntWidth)) u_cnt_igrant (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_grant_i),
    .cnt_o (perf_igrant_o)
  );

  mem_arb_perf_cnt #(.Width(CntWidth)) u_cnt_dgrant (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_grant_d),
    .cnt_o (perf_dgrant_o)
  );

  mem_arb_perf_cnt #(.Width(CntWidth)) u_cnt_stall (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_stall),
    .cnt_o (perf_stall_o)
  );

  assign imem_rdata_o = imem_ready_o ? mem_rdata_i : '0;
  assign dmem_rdata_o = dmem_ready_o ? mem_rdata_i : '0;
  assign mem_req_o    = w_busy;
  assign mem_write_o  = r_write;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        imem_req_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic        imem_ready_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i = 1'b0;
  logic        dmem_write_i = 1'b0;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = '0;
  logic        dmem_ready_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_req_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;
  logic [31:0] perf_igrant_o;
  logic [31:0] perf_dgrant_o;
  logic [31:0] perf_stall_o;
  logic [1:0]  dbg_state_o;

  mem_port_arbiter #(.DWidth(32), .TimeoutCycles(T), .CntWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
    .imem_ready_o(imem_ready_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_write_i(dmem_write_i),
    .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_ready_o(dmem_ready_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o),
    .perf_igrant_o(perf_igrant_o), .perf_dgrant_o(perf_dgrant_o), .perf_stall_o(perf_stall_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [64:0] exp_cmd_q[$];
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  bit          obs_q[$];      // 0 = fetch completed, 1 = data completed
  logic [31:0] obs_data;
  bit          mon_en = 0;
  bit          prev_req = 0;

  // reference model: 0 idle, 1 fetch owns port, 2 data owns port
  int          m_st = 0;
  bit          m_last_d = 0;
  int          m_wait = 0;
  bit          m_err = 0;
  int          m_bc = 0;
  int          m_lat = 0;
  logic [31:0] m_ig = '0, m_dg = '0, m_stall = '0;
  bit          i_rdy, d_rdy;
  int          cyc = 0;
  int          g_edge = 0;

  // requester / responder knobs
  bit          i_act = 0, d_act = 0, i_drop = 0, d_drop = 0, d_wr = 0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  int          i_budget = 0, d_budget = 0;
  int          p_new = 0, p_spur = 0, p_drop = 0;
  int          lat_fix = 0, lat_max = 3;
  bit          rd_fix_en = 0;
  logic [31:0] rd_fix = '0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req_o === 1'b1 && !prev_req) begin
        if (exp_cmd_q.size() == 0) check("mem_req_unexpected", mem_req_o, 1'b0);
        else check("mem_cmd", {mem_addr_o, mem_write_o, mem_wdata_o}, exp_cmd_q.pop_front());
      end
      prev_req = (mem_req_o === 1'b1);
      if (imem_ready_o !== 1'b0) begin
        if (exp_i_q.size() == 0) check("imem_ready_unexpected", imem_ready_o, 1'b0);
        else check("imem_rdata", imem_rdata_o, exp_i_q.pop_front());
        obs_q.push_back(1'b0);
        obs_data = imem_rdata_o;
      end else begin
        check("imem_rdata_idle", imem_rdata_o, 32'h0);
      end
      if (dmem_ready_o !== 1'b0) begin
        if (exp_d_q.size() == 0) check("dmem_ready_unexpected", dmem_ready_o, 1'b0);
        else check("dmem_rdata", dmem_rdata_o, exp_d_q.pop_front());
        obs_q.push_back(1'b1);
        obs_data = dmem_rdata_o;
      end else begin
        check("dmem_rdata_idle", dmem_rdata_o, 32'h0);
      end
    end
  end

  // ---------------- model step + clock edge ----------------
  task automatic tick();
    bit ir, dr, gi, gd;
    ir = imem_req_i;
    dr = dmem_req_i;
    i_rdy = 0;
    d_rdy = 0;
    if (!rst_ni) begin
      m_st = 0; m_last_d = 0; m_wait = 0; m_err = 0; m_bc = 0;
      m_ig = '0; m_dg = '0; m_stall = '0;
    end else begin
      if (m_st == 0) begin
        gd = dr && (!ir || !m_last_d);
        gi = ir && !gd;
        if (gd || gi) begin
          if (gd) exp_cmd_q.push_back({dmem_addr_i, dmem_write_i, dmem_wdata_i});
          else    exp_cmd_q.push_back({imem_addr_i, 1'b0, 32'h0});
          m_st = gd ? 2 : 1;
          m_last_d = gd;
          m_wait = 0;
          m_bc = 0;
          m_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, lat_max));
          if (gd) m_dg++; else m_ig++;
          g_edge = cyc + 1;
        end
      end else if (mem_ready_i) begin
        if (m_st == 1) begin i_rdy = 1; exp_i_q.push_back(mem_rdata_i); end
        else begin d_rdy = 1; exp_d_q.push_back(mem_rdata_i); end
        m_st = 0;
      end else begin
        m_bc++;
        if (m_wait < T) m_wait++;
        if (m_wait == T) m_err = 1;
      end
      if ((ir && !i_rdy) || (dr && !d_rdy)) m_stall++;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("mem_req", mem_req_o, m_st != 0);
    check("err", err_o, m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    imem_req_i   = i_act && !i_drop;
    imem_addr_i  = i_act ? i_addr : $urandom;
    dmem_req_i   = d_act && !d_drop;
    dmem_addr_i  = d_act ? d_addr : $urandom;
    dmem_wdata_i = d_act ? d_wdata : $urandom;
    dmem_write_i = d_act ? d_wr : 1'($urandom_range(0, 1));
  endtask

  task automatic cycle();
    if (m_st != 0 && m_bc >= m_lat) begin
      mem_ready_i = 1'b1;
      mem_rdata_i = rd_fix_en ? rd_fix : $urandom;
    end else if (m_st == 0 && int'($urandom_range(0, 99)) < p_spur) begin
      mem_ready_i = 1'b1;
      mem_rdata_i = $urandom;
    end else begin
      mem_ready_i = 1'b0;
      mem_rdata_i = $urandom;
    end
    tick();
    mem_ready_i = 1'b0;
    if (i_rdy) begin i_act = 0; i_drop = 0; end
    if (d_rdy) begin d_act = 0; d_drop = 0; end
    if (!i_act && i_budget > 0 && int'($urandom_range(0, 99)) < p_new) begin
      i_act = 1; i_addr = $urandom; i_budget--;
    end
    if (!d_act && d_budget > 0 && int'($urandom_range(0, 99)) < p_new) begin
      d_act = 1; d_addr = $urandom; d_wdata = $urandom; d_wr = 1'($urandom_range(0, 1)); d_budget--;
    end
    if (i_act && m_st == 1 && !i_drop && int'($urandom_range(0, 99)) < p_drop) i_drop = 1;
    if (d_act && m_st == 2 && !d_drop && int'($urandom_range(0, 99)) < p_drop) d_drop = 1;
    drive();
  endtask

  task automatic run_until_quiet(input int budget);
    int n = 0;
    while ((i_act || d_act || m_st != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("quiesce_in_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    i_act = 0; d_act = 0; i_drop = 0; d_drop = 0;
    i_budget = 0; d_budget = 0; p_new = 0; p_spur = 0; p_drop = 0;
    rd_fix_en = 0;
    mem_ready_i = 1'b0;
    drive();
    tick();
    rst_ni = 1'b1;
    exp_cmd_q.delete(); exp_i_q.delete(); exp_d_q.delete(); obs_q.delete();
  endtask

  task automatic phase_end(input string name);
    check({name, "_igrant"}, perf_igrant_o, m_ig);
    check({name, "_dgrant"}, perf_dgrant_o, m_dg);
    check({name, "_stall"}, perf_stall_o, m_stall);
    check({name, "_queues_drained"}, exp_cmd_q.size() + exp_i_q.size() + exp_d_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          seen;
    int          rise;
    int          n;
    logic [5:0]  seq6;
    logic [1:0]  seq2;

    drive();
    do_reset();
    mon_en = 1;
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_write", mem_write_o, 1'b0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_imem_ready", imem_ready_o, 1'b0);
    check("rst_dmem_ready", dmem_ready_o, 1'b0);
    check("rst_perf_stall", perf_stall_o, 32'h0);
    check("rst_state", dbg_state_o, 2'(ST_IDLE));

    // lone fetch, memory answers three cycles after the request appears
    lat_fix = 3; rd_fix_en = 1; rd_fix = 32'hDEADBEEF;
    i_act = 1; i_addr = 32'h100; drive();
    run_until_quiet(20);
    check("fetch_pulses", obs_q.size(), 1);
    check("fetch_data", obs_data, 32'hDEADBEEF);
    check("fetch_igrant", perf_igrant_o, 32'd1);
    phase_end("fetch");

    // simultaneous requests straight after reset: data first
    do_reset();
    lat_fix = 1;
    i_act = 1; i_addr = 32'h0;
    d_act = 1; d_wr = 1; d_addr = 32'h4000; d_wdata = 32'h12345678; drive();
    run_until_quiet(20);
    seq2 = {obs_q.size() > 1 ? obs_q[1] : 1'b1, obs_q.size() > 0 ? obs_q[0] : 1'b0};
    check("conflict_count", obs_q.size(), 2);
    check("conflict_order", seq2, 2'b01);
    check("conflict_dgrant", perf_dgrant_o, 32'd1);
    check("conflict_igrant", perf_igrant_o, 32'd1);
    phase_end("conflict");

    // both requesters continuously asking: strict alternation
    do_reset();
    lat_fix = 0; p_new = 100; i_budget = 2; d_budget = 2;
    i_act = 1; i_addr = $urandom;
    d_act = 1; d_addr = $urandom; d_wdata = $urandom; d_wr = 1; drive();
    run_until_quiet(40);
    seq6 = '0;
    for (int k = 0; k < 6; k++) if (k < obs_q.size()) seq6[k] = obs_q[k];
    check("sustained_count", obs_q.size(), 6);
    check("sustained_order", seq6, 6'b010101);
    check("sustained_igrant", perf_igrant_o, 32'd3);
    check("sustained_dgrant", perf_dgrant_o, 32'd3);
    phase_end("sustained");

    // timeout: memory silent past the limit, then answers
    do_reset();
    lat_fix = 12;
    d_act = 1; d_wr = 0; d_addr = 32'h80; d_wdata = $urandom; drive();
    seen = 0; rise = 0; n = 0;
    while ((d_act || m_st != 0) && n < 40) begin
      cycle();
      n++;
      if (!seen && err_o === 1'b1) begin seen = 1; rise = cyc; end
    end
    check("tmo_seen", seen, 1'b1);
    check("tmo_delay", rise - g_edge, T);
    check("tmo_completed", obs_q.size(), 1);
    check("tmo_sticky", err_o, 1'b1);
    phase_end("tmo");

    // reset in the middle of a transfer, late memory answer must be ignored
    do_reset();
    lat_fix = 5;
    i_act = 1; i_addr = 32'h200; drive();
    repeat (3) cycle();
    rst_ni = 1'b0; i_act = 0; i_drop = 0; drive();
    mem_ready_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    mem_ready_i = 1'b1; mem_rdata_i = $urandom;
    tick();
    mem_ready_i = 1'b0;
    tick();
    check("rstmid_pulses", obs_q.size(), 1'b0);
    check("rstmid_addr", mem_addr_o, 32'h0);
    check("rstmid_write", mem_write_o, 1'b0);
    check("rstmid_wdata", mem_wdata_o, 32'h0);
    check("rstmid_igrant", perf_igrant_o, 32'h0);
    check("rstmid_state", dbg_state_o, 2'(ST_IDLE));
    lat_fix = 1;
    i_act = 1; i_addr = 32'h300; drive();
    run_until_quiet(20);
    check("rstmid_regrant", perf_igrant_o, 32'd1);
    check("rstmid_regrant_pulse", obs_q.size(), 1);
    phase_end("rstmid");

    // spurious memory ready while idle
    obs_q.delete();
    p_spur = 100;
    repeat (5) cycle();
    p_spur = 0;
    check("spur_pulses", obs_q.size(), 0);
    check("spur_state", dbg_state_o, 2'(ST_IDLE));
    phase_end("spur");

    // randomised traffic
    do_reset();
    lat_fix = -1; lat_max = 10;
    p_new = 30; p_spur = 20; p_drop = 10; i_budget = 100000; d_budget = 100000;
    repeat (2500) cycle();
    p_new = 0; p_drop = 0;
    run_until_quiet(100);
    phase_end("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): DWidth, 32, data/address width; TimeoutCycles, 1024, cycles from grant to err_o; CntWidth, 32, perf counter width.
REQ-002 clk_i  input  1  core clock; the only clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset; synchronous, active-low.
REQ-004 imem_req_i / imem_addr_i  input  1 / DWidth  fetch request and word address, held until imem_ready_o.
REQ-005 imem_ready_o / imem_rdata_o  output  1 / DWidth  one-cycle completion pulse; read data valid that cycle.
REQ-006 dmem_req_i, dmem_write_i / dmem_addr_i, dmem_wdata_i  input  1, 1 / DWidth, DWidth  load/store request, held until dmem_ready_o.
REQ-007 dmem_ready_o / dmem_rdata_o  output  1 / DWidth  one-cycle completion pulse; load data valid that cycle.
REQ-008 mem_req_o, mem_write_o / mem_addr_o, mem_wdata_o  output  1, 1 / DWidth, DWidth  unified memory port.
REQ-009 mem_ready_i / mem_rdata_i  input  1 / DWidth  one-cycle completion pulse from memory; data valid that cycle.
REQ-010 err_o  output  1  sticky timeout flag.
REQ-011 perf_igrant_o, perf_dgrant_o, perf_stall_o  output  CntWidth each  fetch grants, data grants, stall cycles.

Function
REQ-012 FSM states IDLE, BUSY_I, BUSY_D; at most one memory transaction outstanding.
REQ-013 IDLE: if any request is high at edge t, grant exactly one, capture its addr/write/wdata (fetch: write=0, wdata=0) and enter BUSY_I/BUSY_D at t+1.
REQ-014 Arbitration is round-robin: on a simultaneous request, the requester not granted last wins; last-grant pointer resets to "imem", so dmem wins the first conflict.
REQ-015 In BUSY_x, mem_req_o=1 and mem_addr_o/mem_write_o/mem_wdata_o drive the captured values, stable until completion.
REQ-016 mem_ready_i in BUSY_x combinationally drives the matching x_ready_o=1 and x_rdata_o=mem_rdata_i in the same cycle; the FSM returns to IDLE next edge and mem_req_o drops.
REQ-017 Minimum occupancy: 2 cycles per transaction (grant edge + ready cycle); one IDLE bubble between back-to-back transactions.
REQ-018 mem_ready_i while IDLE is ignored; no ready_o pulse.
REQ-019 Non-granted requester sees ready_o=0; rdata outputs are 0 whenever the matching ready_o=0.
REQ-020 Requester dropping req mid-transaction: transaction still completes and ready_o still pulses.
REQ-021 Timeout counter clears on grant and increments each BUSY cycle without mem_ready_i; on reaching TimeoutCycles err_o sets and stays 1 until reset; FSM keeps waiting (no abort).
REQ-022 perf_igrant_o/perf_dgrant_o increment on the grant edge; perf_stall_o increments each cycle in which any req_i is high and its ready_o is low; all wrap modulo 2^CntWidth.

Reset
REQ-023 rst_ni=0 at an edge: state IDLE, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, ready_o both 0, rdata both 0, err_o=0, all counters 0, pointer = imem.
REQ-024 Reset mid-transaction abandons it; a later mem_ready_i for it is ignored under REQ-018.

Structure
REQ-025 Shared package mem_arb_pkg holds the state enum typedef, the grant-select typedef and the default TimeoutCycles/CntWidth constants.
REQ-026 One sub-module, mem_arb_perf_cnt (enable-driven wrapping counter, parameterized width), is instantiated three times; FSM, capture and timeout logic stay in mem_port_arbiter.

Verification
REQ-027 Lone fetch: imem_req_i=1, addr 0x100; memory ready 3 cycles after mem_req_o with rdata 0xDEADBEEF -> mem_addr_o=0x100, write=0, imem_ready_o one pulse with 0xDEADBEEF, perf_igrant_o=1.
REQ-028 Conflict from reset: both req at the same edge (dmem store 0x4000/0x12345678, imem 0x0) -> dmem granted first (mem_write_o=1), imem second after one bubble; perf_dgrant_o=1, perf_igrant_o=1.
REQ-029 Sustained conflict, 6 transactions with both requests held -> grants alternate D,I,D,I,D,I; each counter ends at 3.
REQ-030 Timeout: TimeoutCycles=8, no mem_ready_i -> err_o rises exactly 8 cycles after grant; a later ready still completes, and err_o stays 1.
REQ-031 Reset mid-transaction, then mem_ready_i one cycle after reset release -> no ready_o pulse; all outputs at reset values; next request is granted normally.
REQ-032 Spurious mem_ready_i in IDLE -> no ready_o pulse, state unchanged, counters unchanged.
